csi_raw10_unpacker: RTL

- Sits directly downstream of the CSI packet handler, in the rxbyteclkhs domain.
- Consumes the 16-bit payload stream, the frame/line qualifiers and the last-packet flag.
- Unpacks MIPI CSI-2 RAW10 payload (5 bytes → 4 pixels) into 4-pixel words and generates line/frame markers and per-line pixel counts for the pixel pipeline.
- Streaming only: no backpressure, so the output rate averages 1.6 pixels/cycle.

---
 rtl/csi_raw10_unpacker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/csi_raw10_unpacker.sv
// CSI-2 RAW10 payload unpacker: turns a 2-byte/cycle line stream into 4-pixel groups
// with line/frame markers and a per-line pixel count.
module csi_raw10_unpacker #(
    parameter int IN_STREAM_WIDTH   = 16,
    parameter int PIXEL_COUNT_WIDTH = 16
) (
    input  logic                         rxbyteclkhs,
    input  logic                         reset,
    input  logic [IN_STREAM_WIDTH-1:0]   in_stream,
    input  logic                         in_stream_valid,
    input  logic                         frame_active,
    input  logic                         last_packet,
    output logic [39:0]                  pixels,
    output logic                         pixels_valid,
    output logic                         line_start,
    output logic                         line_end,
    output logic                         frame_end,
    output logic                         partial_group,
    output logic [PIXEL_COUNT_WIDTH-1:0] line_pixels
);

    localparam logic [PIXEL_COUNT_WIDTH-1:0] COUNT_MAX  = '1;
    localparam logic [PIXEL_COUNT_WIDTH-1:0] COUNT_STEP = PIXEL_COUNT_WIDTH'(4);

    logic [2:0]                   phase;
    logic [7:0]                   held_0, held_1, held_2, held_3;
    logic                         prev_valid;
    logic                         lp_latch;
    logic                         emitted;
    logic [PIXEL_COUNT_WIDTH-1:0] pixel_count;

    logic [7:0]  lo_byte, hi_byte;
    logic        word_ok, line_done, emit;
    logic [39:0] group;
    logic [PIXEL_COUNT_WIDTH-1:0] count_next;

    assign lo_byte   = in_stream[7:0];
    assign hi_byte   = in_stream[15:8];
    assign word_ok   = frame_active & in_stream_valid;
    assign line_done = frame_active & ~in_stream_valid & prev_valid;

    // Phase 2 closes group A with the LSB byte in the low half; phase 4 closes
    // group B with P4's MSB in the low half and the LSB byte in the high half.
    always_comb begin
        emit  = 1'b0;
        group = '0;
        if (word_ok && phase == 3'd2) begin
            emit  = 1'b1;
            group = {held_3, lo_byte[7:6], held_2, lo_byte[5:4],
                     held_1, lo_byte[3:2], held_0, lo_byte[1:0]};
        end else if (word_ok && phase == 3'd4) begin
            emit  = 1'b1;
            group = {lo_byte, hi_byte[7:6], held_2, hi_byte[5:4],
                     held_1, hi_byte[3:2], held_0, hi_byte[1:0]};
        end
    end

    always_comb begin
        if (pixel_count > COUNT_MAX - COUNT_STEP) count_next = COUNT_MAX;
        else                                      count_next = pixel_count + COUNT_STEP;
    end

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            phase         <= 3'd0;
            held_0        <= 8'd0;
            held_1        <= 8'd0;
            held_2        <= 8'd0;
            held_3        <= 8'd0;
            prev_valid    <= 1'b0;
            lp_latch      <= 1'b0;
            emitted       <= 1'b0;
            pixel_count   <= '0;
            pixels        <= '0;
            pixels_valid  <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            frame_end     <= 1'b0;
            partial_group <= 1'b0;
            line_pixels   <= '0;
        end else begin
            pixels_valid  <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            frame_end     <= 1'b0;
            partial_group <= 1'b0;
            if (!frame_active) begin
                phase       <= 3'd0;
                held_0      <= 8'd0;
                held_1      <= 8'd0;
                held_2      <= 8'd0;
                held_3      <= 8'd0;
                prev_valid  <= 1'b0;
                lp_latch    <= 1'b0;
                emitted     <= 1'b0;
                pixel_count <= '0;
            end else begin
                prev_valid <= in_stream_valid;
                if (in_stream_valid) begin
                    lp_latch <= lp_latch | last_packet;
                    phase    <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
                    case (phase)
                        3'd0: begin held_0 <= lo_byte; held_1 <= hi_byte; end
                        3'd1: begin held_2 <= lo_byte; held_3 <= hi_byte; end
                        3'd2: held_0 <= hi_byte;
                        3'd3: begin held_1 <= lo_byte; held_2 <= hi_byte; end
                        default: ;
                    endcase
                    if (emit) begin
                        pixels       <= group;
                        pixels_valid <= 1'b1;
                        line_start   <= ~emitted;
                        emitted      <= 1'b1;
                        pixel_count  <= count_next;
                    end
                end else if (line_done) begin
                    // Close the line: publish the count and drop any half-built group.
                    line_end      <= 1'b1;
                    frame_end     <= lp_latch;
                    partial_group <= (phase != 3'd0);
                    line_pixels   <= pixel_count;
                    pixel_count   <= '0;
                    lp_latch      <= 1'b0;
                    emitted       <= 1'b0;
                    phase         <= 3'd0;
                    held_0        <= 8'd0;
                    held_1        <= 8'd0;
                    held_2        <= 8'd0;
                    held_3        <= 8'd0;
                end
            end
        end
    end

endmodule
